// File: rtl/pixel_sync_fifo.sv
// pixel_sync_fifo: single-clock pixel buffer between the pixel front end and
// conv layer 1. Holds an occupancy count, with flags derived from it,
// programmable almost-full/almost-empty thresholds, FWFT or registered read
// mode, synchronous flush and sticky overflow/underflow error flags.
module pixel_sync_fifo #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 1024,
  parameter int AF_THRESH = 140,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 1
) (
  input  logic                       i_sys_clk,
  input  logic                       i_rst,
  input  logic                       i_flush,
  input  logic                       i_wr_en,
  input  logic [DATA_W-1:0]          i_feature,
  input  logic                       i_rd_en,
  input  logic                       i_clr_err,
  output logic [DATA_W-1:0]          o_feature,
  output logic                       o_feature_valid,
  output logic                       o_full,
  output logic                       o_empty,
  output logic                       o_almost_full,
  output logic                       o_almost_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_overflow,
  output logic                       o_underflow
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             wrAcc, rdAcc;
  logic [ADDR_W-1:0] rdIdx;

  assign rdIdx = rdPtr_q[ADDR_W-1:0];

  // Status flags are pure functions of the registered occupancy count.
  assign o_count        = count_q;
  assign o_full         = (count_q == DEPTH_C);
  assign o_empty        = (count_q == '0);
  assign o_almost_full  = (count_q >= AF_C);
  assign o_almost_empty = (count_q <= AE_C);
  assign o_overflow     = overflow_q;
  assign o_underflow    = underflow_q;

  // A flush suppresses both transfers, so a write into a full FIFO or a read
  // from an empty one in the flush cycle is simply ignored.
  assign wrAcc = i_wr_en & ~o_full & ~i_flush;
  assign rdAcc = i_rd_en & ~o_empty & ~i_flush;

  // Next-state for pointers, count and sticky errors; a fresh error beats a clear.
  always_comb begin
    wrPtr_d     = wrPtr_q;
    rdPtr_d     = rdPtr_q;
    count_d     = count_q;
    overflow_d  = (overflow_q & ~i_clr_err) | (i_wr_en & o_full & ~i_flush);
    underflow_d = (underflow_q & ~i_clr_err) | (i_rd_en & o_empty & ~i_flush);
    if (i_flush) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (wrAcc) wrPtr_d = wrPtr_q + PTR_W'(1);
      if (rdAcc) rdPtr_d = rdPtr_q + PTR_W'(1);
      if (wrAcc && !rdAcc)      count_d = count_q + CNT_W'(1);
      else if (rdAcc && !wrAcc) count_d = count_q - CNT_W'(1);
    end
  end

  // Control state registers, cleared asynchronously.
  always_ff @(posedge i_sys_clk or posedge i_rst) begin
    if (i_rst) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array carries no reset so it can map onto block RAM.
  always_ff @(posedge i_sys_clk) begin
    if (wrAcc) mem[wrPtr_q[ADDR_W-1:0]] <= i_feature;
  end

  // The extra pointer bit keeps the pointer difference equal to the count.
  assert property (@(posedge i_sys_clk) disable iff (i_rst)
    count_q == CNT_W'(wrPtr_q - rdPtr_q));

  generate
    if (FWFT != 0) begin : g_fwft
      // Head entry is presented directly; zero while nothing is held.
      assign o_feature       = o_empty ? '0 : mem[rdIdx];
      assign o_feature_valid = ~o_empty;
    end else begin : g_std
      logic [DATA_W-1:0] feature_q;
      logic              featureValid_q;

      // Registered read port: data lands one cycle after an accepted pop and holds.
      always_ff @(posedge i_sys_clk or posedge i_rst) begin
        if (i_rst) begin
          feature_q      <= '0;
          featureValid_q <= 1'b0;
        end else begin
          featureValid_q <= rdAcc;
          if (rdAcc) feature_q <= mem[rdIdx];
        end
      end

      assign o_feature       = feature_q;
      assign o_feature_valid = featureValid_q;
    end
  endgenerate

endmodule
